// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha_pkg
// Description : Shared SHA-256 block-sequencing constants and the controller
//               state encoding. The controller, the hash core and
//               msg_done_gen all use this package.
//               ROUNDS    : compression rounds per block
//               MSG_WORDS : words read from message memory per block
//               ADDR_W    : message memory address width
//               RND_W     : round index width
// Revision    : 1.0 - initial release
// ============================================================================
package sha_pkg;

    localparam int ROUNDS    = 64;
    localparam int MSG_WORDS = 16;
    localparam int ADDR_W    = 4;
    localparam int RND_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_EXPAND = 3'd2,
        ST_FINAL  = 3'd3,
        ST_DONE   = 3'd4
    } sha_state_t;

endpackage : sha_pkg
`default_nettype wire

// File: rtl/msg_round_cnt.sv
`default_nettype none
// ============================================================================
// Module      : msg_round_cnt
// Description : Round issue counter with clear/increment controls and two
//               terminal-count flags.
//   clock     in  rising-edge clock
//   reset     in  asynchronous active-high reset
//   clear     in  synchronous clear (takes priority over inc)
//   inc       in  advance the counter by one
//   cnt       out current round index
//   tc_msg    out cnt == MSG_WORDS-1 (last message-memory round)
//   tc_rounds out cnt == ROUNDS-1    (last compression round)
// Revision    : 1.0 - initial release
// ============================================================================
module msg_round_cnt #(
    parameter int ROUNDS    = 64,
    parameter int MSG_WORDS = 16,
    parameter int RND_W     = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [RND_W-1:0] cnt,
    output logic             tc_msg,
    output logic             tc_rounds
);

    localparam logic [RND_W-1:0] C_TC_MSG    = RND_W'(MSG_WORDS - 1);
    localparam logic [RND_W-1:0] C_TC_ROUNDS = RND_W'(ROUNDS - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc_msg    = (cnt == C_TC_MSG);
    assign tc_rounds = (cnt == C_TC_ROUNDS);

endmodule : msg_round_cnt
`default_nettype wire

// File: rtl/msg_done_gen.sv
`default_nettype none
// ============================================================================
// Module      : msg_done_gen
// Description : Terminator of the sticky message-enable handshake. A rising
//               edge of enable starts one block: MSG_WORDS message-memory
//               reads followed by schedule-expansion rounds, ROUNDS in total.
//               done is raised afterwards and held until ack.
//   clock       in  rising-edge clock
//   reset       in  asynchronous active-high reset
//   enable      in  sticky go level from the message-enable stage
//   ack         in  controller has taken the digest; releases done
//   mem_rd_en   out message memory read strobe
//   mem_addr    out message memory word address
//   round_valid out round/word_sel valid (one cycle behind the memory read)
//   round       out current round index
//   word_sel    out 1: W from memory data, 0: W from schedule expansion
//   busy        out high from LOAD entry until DONE exit
//   done        out block complete, held until ack
// Revision    : 1.0 - initial release
// ============================================================================
module msg_done_gen #(
    parameter int ROUNDS    = sha_pkg::ROUNDS,
    parameter int MSG_WORDS = sha_pkg::MSG_WORDS,
    parameter int ADDR_W    = sha_pkg::ADDR_W,
    parameter int RND_W     = sha_pkg::RND_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              ack,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              round_valid,
    output logic [RND_W-1:0]  round,
    output logic              word_sel,
    output logic              busy,
    output logic              done
);

    import sha_pkg::*;

    sha_state_t       r_state;
    logic             r_enable_q;
    logic [RND_W-1:0] w_cnt;
    logic             w_tc_msg;
    logic             w_tc_rounds;
    logic             w_start;
    logic             w_issue;
    logic             w_inc;
    logic             w_clear;

    // Only a 0->1 transition starts a block; a held level is not a request.
    assign w_start = enable & ~r_enable_q;

    // A round is issued in every LOAD and EXPAND cycle.
    assign w_issue = (r_state == ST_LOAD) || (r_state == ST_EXPAND);

    // Stop advancing on the last round so the index never wraps inside a block.
    assign w_inc   = (r_state == ST_LOAD) ||
                     ((r_state == ST_EXPAND) && !w_tc_rounds);

    // The counter clears as the FSM returns to IDLE.
    assign w_clear = (r_state == ST_DONE) && ack;

    msg_round_cnt #(
        .ROUNDS    (ROUNDS),
        .MSG_WORDS (MSG_WORDS),
        .RND_W     (RND_W)
    ) u_round_cnt (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_clear),
        .inc       (w_inc),
        .cnt       (w_cnt),
        .tc_msg    (w_tc_msg),
        .tc_rounds (w_tc_rounds)
    );

    // FSM, edge-detect register and the one-stage round output pipe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_enable_q  <= 1'b0;
            round_valid <= 1'b0;
            round       <= '0;
            word_sel    <= 1'b0;
        end else begin
            r_enable_q  <= enable;
            round_valid <= w_issue;
            if (w_issue) begin
                round    <= w_cnt;
                word_sel <= (r_state == ST_LOAD);
            end

            case (r_state)
                ST_IDLE:   if (w_start)     r_state <= ST_LOAD;
                ST_LOAD:   if (w_tc_msg)    r_state <= ST_EXPAND;
                ST_EXPAND: if (w_tc_rounds) r_state <= ST_FINAL;
                ST_FINAL:                   r_state <= ST_DONE;
                ST_DONE:   if (ack)         r_state <= ST_IDLE;
                default:                    r_state <= ST_IDLE;
            endcase
        end
    end

    // Straight decodes of the state and counter flops.
    assign mem_rd_en = (r_state == ST_LOAD);
    assign mem_addr  = (r_state == ST_LOAD) ? w_cnt[ADDR_W-1:0] : '0;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule : msg_done_gen
`default_nettype wire

// File: tb/tb_msg_done_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_msg_done_gen
// Description : Self-checking bench for msg_done_gen. A cycle-count reference
//               model predicts every output from the time elapsed since the
//               start edge. Expected round/word_sel/address sequences are
//               queued when a block starts and popped whenever the DUT
//               presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_done_gen;

    localparam int ROUNDS    = 64;
    localparam int MSG_WORDS = 16;
    localparam int ADDR_W    = 4;
    localparam int RND_W     = 6;
    localparam int T_DONE    = ROUNDS + 2;   // first done cycle after the start edge

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              ack;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              round_valid;
    logic [RND_W-1:0]  round;
    logic              word_sel;
    logic              busy;
    logic              done;

    always #5 clock = ~clock;

    msg_done_gen #(
        .ROUNDS    (ROUNDS),
        .MSG_WORDS (MSG_WORDS),
        .ADDR_W    (ADDR_W),
        .RND_W     (RND_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .ack         (ack),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .round_valid (round_valid),
        .round       (round),
        .word_sel    (word_sel),
        .busy        (busy),
        .done        (done)
    );

    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: m_t = cycles since the start edge (0 = idle),
    // saturating at T_DONE while waiting for ack.
    int   m_t    = 0;
    logic m_prev = 1'b0;
    int   exp_round_q[$];
    int   exp_ws_q[$];
    int   exp_addr_q[$];

    int   rv_count  = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_t    = 0;
            m_prev = 1'b0;
            exp_round_q.delete();
            exp_ws_q.delete();
            exp_addr_q.delete();
        end else begin
            if (m_t == 0) begin
                if (enable && !m_prev) begin
                    m_t = 1;
                    for (int r = 0; r < ROUNDS; r++) begin
                        exp_round_q.push_back(r);
                        exp_ws_q.push_back((r < MSG_WORDS) ? 1 : 0);
                    end
                    for (int a = 0; a < MSG_WORDS; a++) exp_addr_q.push_back(a);
                end
            end else if (m_t < T_DONE) begin
                m_t++;
            end else if (ack) begin
                m_t = 0;
            end
            m_prev = enable;
        end
    end

    // Monitor: per-cycle timing against the model plus scoreboard pops.
    always @(negedge clock) begin
        check("busy",        {31'd0, busy},        {31'd0, (m_t != 0)});
        check("done",        {31'd0, done},        {31'd0, (m_t == T_DONE)});
        check("mem_rd_en",   {31'd0, mem_rd_en},   {31'd0, (m_t >= 1 && m_t <= MSG_WORDS)});
        check("mem_addr",    32'(mem_addr),        (m_t >= 1 && m_t <= MSG_WORDS) ? 32'(m_t - 1) : 32'd0);
        check("round_valid", {31'd0, round_valid}, {31'd0, (m_t >= 2 && m_t <= ROUNDS + 1)});

        if (mem_rd_en) begin
            if (exp_addr_q.size() == 0) flag_fail("sb_addr_unexpected");
            else check("sb_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        end
        if (round_valid) begin
            rv_count++;
            if (exp_round_q.size() == 0) flag_fail("sb_round_unexpected");
            else begin
                check("sb_round",    32'(round),    32'(exp_round_q.pop_front()));
                check("sb_word_sel", 32'(word_sel), 32'(exp_ws_q.pop_front()));
            end
        end

        if (reset) begin
            rv_count = 0;
        end else if (done && !done_prev) begin
            check("rv_per_block", 32'(rv_count), 32'(ROUNDS));
            rv_count = 0;
        end
        done_prev = done;
    end

    task automatic wait_t(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (m_t != target && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        if (m_t != target) flag_fail({name, "_timeout"});
    endtask

    task automatic start_block();
        enable = 1'b0;
        @(posedge clock); #1;
        enable = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int  hold;
        int  guard;
        bit  seen_done;

        reset  = 1'b1;
        enable = 1'b0;
        ack    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_round",    32'(round),    32'd0);
        check("reset_word_sel", 32'(word_sel), 32'd0);
        check("reset_done",     32'(done),     32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // 1: ack held high gives a single-cycle done.
        ack = 1'b1;
        repeat (2) @(posedge clock); #1;
        enable = 1'b1;
        @(posedge clock); #1;
        wait_t(T_DONE, 100, "t1_done");
        wait_t(0, 5, "t1_idle");
        // Enable stays high: no restart.
        repeat (10) @(posedge clock); #1;
        check("t1_no_restart", 32'(busy), 32'd0);

        // 2: done held until ack.
        ack = 1'b0;
        start_block();
        wait_t(T_DONE, 100, "t2_done");
        repeat (25) @(posedge clock); #1;
        check("t2_done_held", 32'(done), 32'd1);
        ack = 1'b1;
        @(posedge clock); #1;
        ack = 1'b0;
        check("t2_done_release", 32'(done), 32'd0);
        check("t2_busy_release", 32'(busy), 32'd0);
        repeat (5) @(posedge clock); #1;

        // 5: ack during EXPAND is ignored.
        start_block();
        wait_t(40, 60, "t5_cycle40");
        ack = 1'b1;
        @(posedge clock); #1;
        ack = 1'b0;
        wait_t(T_DONE, 100, "t5_done");
        ack = 1'b1;
        wait_t(0, 5, "t5_idle");
        ack = 1'b0;

        // 4: asynchronous reset mid-block, released with enable still high.
        ack = 1'b1;
        start_block();
        wait_t(30, 60, "t4_cycle30");
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        check("t4_async_busy",      32'(busy),        32'd0);
        check("t4_async_rd_en",     32'(mem_rd_en),   32'd0);
        check("t4_async_rvalid",    32'(round_valid), 32'd0);
        check("t4_async_round",     32'(round),       32'd0);
        repeat (2) @(posedge clock); #1;
        reset = 1'b0;
        wait_t(T_DONE, 120, "t4_done");
        wait_t(0, 5, "t4_idle");

        // 6 + random blocks: enable toggles and ack pulses during busy,
        // random ack latency in DONE.
        for (int b = 0; b < 6; b++) begin
            ack       = 1'b0;
            hold      = $urandom_range(0, 6);
            seen_done = 1'b0;
            guard     = 0;
            start_block();
            while (guard < 400) begin
                if (m_t >= 1 && m_t < 60) begin
                    if ($urandom_range(0, 4) == 0) enable = ~enable;
                    ack = ($urandom_range(0, 5) == 0);
                end else if (m_t >= 60 && m_t < T_DONE) begin
                    enable = 1'b1;
                    ack    = 1'b0;
                end else if (m_t == T_DONE) begin
                    enable    = 1'b1;
                    seen_done = 1'b1;
                    if (hold == 0) ack = 1'b1;
                    else begin
                        hold--;
                        ack = 1'b0;
                    end
                end else if (seen_done) begin
                    break;
                end
                @(posedge clock); #1;
                guard++;
            end
            ack = 1'b0;
            if (!seen_done || m_t != 0) flag_fail("rand_block_timeout");
        end

        repeat (5) @(posedge clock); #1;
        check("sb_round_leftover", 32'(exp_round_q.size()), 32'd0);
        check("sb_addr_leftover",  32'(exp_addr_q.size()),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_msg_done_gen
`default_nettype wire
